// File: rtl/xnor_cmp_pipe_if.sv
// Handshake bundle for xnor_cmp_pipe.
//   Upstream side: in_valid, in_ready, a, b, op.
//   Downstream side: out_valid, out_ready, y, match_cnt, eq.
// The master modport is the producer/consumer environment. The slave modport is the compare stage.
interface xnor_cmp_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned MW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [MW-1:0]    match_cnt;
  logic             eq;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, match_cnt, eq
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, match_cnt, eq
  );
endinterface

// File: rtl/xnor_cmp_pipe.sv
// Registered bitwise gate / word compare stage with valid/ready handshake.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : handshake bundle (slave side): operands a/b, opcode op, result y,
//                match_cnt (popcount of a XNOR b), eq (a == b)
//   clr_cnt    : synchronous clear of eq_count (wins over an increment)
//   eq_count   : saturating count of delivered results with eq = 1
// The interface instance must be parameterised with the same WIDTH.
module xnor_cmp_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  xnor_cmp_pipe_if.slave     bus,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   eq_count
);

  localparam int unsigned MW = $clog2(WIDTH + 1);

  logic             valid_q;
  logic [WIDTH-1:0] y_q, y_d;
  logic [MW-1:0]    match_q, match_d;
  logic             eq_q, eq_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] xn;
  logic             in_ready;
  logic             accept;
  logic             xfer;

  // No skid buffer: a slot opens only when the held word leaves this cycle.
  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = valid_q && bus.out_ready;

  assign xn = ~(bus.a ^ bus.b);

  always_comb begin
    match_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      match_d = match_d + MW'(xn[i]);
    end
    eq_d = (match_d == MW'(WIDTH));
  end

  always_comb begin
    y_d = bus.a;
    case (bus.op)
      3'd0:    y_d = bus.a & bus.b;
      3'd1:    y_d = bus.a | bus.b;
      3'd2:    y_d = bus.a ^ bus.b;
      3'd3:    y_d = ~(bus.a ^ bus.b);
      3'd4:    y_d = ~(bus.a & bus.b);
      3'd5:    y_d = ~(bus.a | bus.b);
      3'd6:    y_d = ~bus.a;
      default: y_d = bus.a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      match_q <= '0;
      eq_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        y_q     <= y_d;
        match_q <= match_d;
        eq_q    <= eq_d;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      // Counts the word leaving now, i.e. the held eq_q, not the one arriving.
      if (clr_cnt) begin
        cnt_q <= '0;
      end else if (xfer && eq_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.y         = y_q;
  assign bus.match_cnt = match_q;
  assign bus.eq        = eq_q;
  assign eq_count      = cnt_q;

endmodule

// File: tb/tb_xnor_cmp_pipe.sv
module tb_xnor_cmp_pipe;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] eq_count;

  int vectors = 0;
  int errors  = 0;

  xnor_cmp_pipe_if #(.WIDTH(WIDTH)) bus ();

  xnor_cmp_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_cnt  (clr_cnt),
    .eq_count (eq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one result slot plus an event counter.
  int        m_valid = 0;
  logic [7:0] m_y = '0;
  int        m_match = 0;
  int        m_eq = 0;
  int        m_cnt = 0;

  function automatic logic [7:0] gate(input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] x;
    bit acc, xf;
    if (!rst_n) begin
      m_valid <= 0; m_y <= '0; m_match <= 0; m_eq <= 0; m_cnt <= 0;
    end else begin
      xf  = (m_valid != 0) && bus.out_ready;
      acc = bus.in_valid && ((m_valid == 0) || bus.out_ready);
      x   = ~(bus.a ^ bus.b);
      if (acc) begin
        m_valid <= 1;
        m_y     <= gate(bus.op, bus.a, bus.b);
        m_match <= $countones(x);
        m_eq    <= (bus.a == bus.b) ? 1 : 0;
      end else if (xf) begin
        m_valid <= 0;
      end
      if (clr_cnt) m_cnt <= 0;
      else if (xf && m_eq != 0 && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("in_ready", 32'(bus.in_ready), 32'((m_valid == 0) || bus.out_ready));
    chk("eq_count", 32'(eq_count), 32'(m_cnt));
    if (m_valid != 0) begin
      chk("y", 32'(bus.y), 32'(m_y));
      chk("match_cnt", 32'(bus.match_cnt), 32'(m_match));
      chk("eq", 32'(bus.eq), 32'(m_eq));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;

    // Reset then idle.
    repeat (3) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_eq_count", 32'(eq_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Opcode sweep, back-to-back.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'hF0;
      bus.b = 8'hCC;
      bus.op = 3'(i);
      step();
      chk("sweep_valid", 32'(bus.out_valid), 32'd1);
      chk("sweep_y", 32'(bus.y), 32'(sweep_exp[i]));
      chk("sweep_match", 32'(bus.match_cnt), 32'd4);
      chk("sweep_eq", 32'(bus.eq), 32'd0);
    end

    // Back-pressure with new data offered during the stall.
    bus.a = 8'h5A; bus.b = 8'h5A; bus.op = 3'd3;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a = 8'(i * 17 + 3); bus.b = 8'(i * 5); bus.op = 3'(i);
      step();
      chk("stall_y", 32'(bus.y), 32'hFF);
      chk("stall_eq", 32'(bus.eq), 32'd1);
      chk("stall_match", 32'(bus.match_cnt), 32'd8);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_eq_count", 32'(eq_count), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.a = 8'h11; bus.b = 8'h22; bus.op = 3'd0;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("release_eq_count", 32'(eq_count), 32'd1);
    chk("release_y", 32'(bus.y), 32'h00);

    // Saturation: 17 equal words streamed, then drained.
    for (int i = 0; i < 17; i++) begin
      bus.a = 8'(i * 13); bus.b = 8'(i * 13); bus.op = 3'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("sat_eq_count", 32'(eq_count), 32'(CMAX));

    // Clear wins over a coinciding equal-word transfer.
    bus.in_valid = 1'b1; bus.a = 8'h77; bus.b = 8'h77;
    step();
    bus.in_valid = 1'b0;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_eq_count", 32'(eq_count), 32'd0);

    // Build a nonzero count, then reset asynchronously in the middle of a stall.
    bus.in_valid = 1'b1; bus.a = 8'h3C; bus.b = 8'h3C;
    step();
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_eq_count", 32'(eq_count), 32'd0);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("arst_no_replay", 32'(bus.out_valid), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.op        = 3'($urandom_range(0, 7));
      bus.a         = 8'($urandom);
      bus.b         = ($urandom_range(0, 2) == 0) ? bus.a : 8'($urandom);
      if ($urandom_range(0, 3) == 0) bus.b = bus.a ^ (8'd1 << $urandom_range(0, 7));
      clr_cnt       = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
